sprite_anim_disp: RTL and testbench



---
 rtl/sprite_anim_disp_if.sv | 39 +++
 rtl/sprite_anim_disp.sv | 167 ++++++++++++++++
 tb/tb_sprite_anim_disp.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_anim_disp_if.sv
// Pixel-stream and sprite-ROM bundle for sprite_anim_disp.
//   frame_tick/mode/pos_x/pos_y : per-frame control from the display timing block
//   x/y/bg_in                    : current pixel position and lower-layer colour
//   rom_addr/rom_data            : 1-cycle synchronous sprite ROM port
//   pixel_data/frame_idx         : composited colour and current animation frame
// Widths are derived from the same sprite geometry parameters as the layer.
interface sprite_anim_disp_if #(
    parameter int unsigned SPR_W  = 26,
    parameter int unsigned SPR_H  = 25,
    parameter int unsigned FRAMES = 4
);
    localparam int unsigned DEPTH = FRAMES * SPR_W * SPR_H;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FIW   = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    logic           frame_tick;
    logic [1:0]     mode;
    logic [6:0]     pos_x;
    logic [5:0]     pos_y;
    logic [6:0]     x;
    logic [5:0]     y;
    logic [15:0]    bg_in;
    logic [AW-1:0]  rom_addr;
    logic [1:0]     rom_data;
    logic [15:0]    pixel_data;
    logic [FIW-1:0] frame_idx;

    // Layer side.
    modport slave (
        input  frame_tick, mode, pos_x, pos_y, x, y, bg_in, rom_data,
        output rom_addr, pixel_data, frame_idx
    );

    // Display timing / ROM side.
    modport master (
        output frame_tick, mode, pos_x, pos_y, x, y, bg_in, rom_data,
        input  rom_addr, pixel_data, frame_idx
    );
endinterface

// File: rtl/sprite_anim_disp.sv
// Palette-indexed sprite layer for the 96x64 RGB565 OLED path.
// Renders an SPR_W x SPR_H sprite at a frame-latched position with
// off / blink / steady / animate modes. Index 0 is transparent and passes
// bg_in through, so layers chain pixel-by-pixel.
// Ports:
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   bus        : sprite_anim_disp_if.slave (control, pixel stream, ROM port)
// Pipeline: x/y/bg_in sampled at edge k -> rom_addr at k, ROM read at k+1,
// pixel_data registered at k+2.
module sprite_anim_disp #(
    parameter int unsigned SPR_W     = 26,
    parameter int unsigned SPR_H     = 25,
    parameter int unsigned FRAMES    = 4,
    parameter int unsigned FRAME_DIV = 8,
    parameter int unsigned BLINK_DIV = 16,
    parameter logic [15:0] PAL1      = 16'hFFFF,
    parameter logic [15:0] PAL2      = 16'h8410,
    parameter logic [15:0] PAL3      = 16'hF100
) (
    input  logic              clk,
    input  logic              rst_n,
    sprite_anim_disp_if.slave bus
);

    localparam int unsigned DEPTH = FRAMES * SPR_W * SPR_H;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FIW   = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int unsigned HW    = (AW + 1 > 8) ? AW + 1 : 8;
    localparam int unsigned FCW   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned BCW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_STEADY = 2'b10,
        MODE_ANIM   = 2'b11
    } mode_e;

    mode_e          mode_c;
    logic [6:0]     px;
    logic [5:0]     py;
    logic [BCW-1:0] blink_cnt;
    logic           blink_on;
    logic [FCW-1:0] anim_cnt;
    logic [FIW-1:0] frame_q;

    logic           visible_c;
    logic           hit_c;
    logic [AW-1:0]  addr_c;
    logic [HW-1:0]  xe, ye, pxe, pye, p, q;

    logic [AW-1:0]  rom_addr_q;
    logic           hit_d1, hit_d2;
    logic [15:0]    bg_d1, bg_d2;
    logic [15:0]    pix_c;
    logic [15:0]    pixel_q;

    assign mode_c         = mode_e'(bus.mode);
    assign bus.rom_addr   = rom_addr_q;
    assign bus.pixel_data = pixel_q;
    assign bus.frame_idx  = frame_q;

    // Position only moves on a frame boundary so the sprite never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px <= '0;
            py <= '0;
        end else if (bus.frame_tick) begin
            px <= bus.pos_x;
            py <= bus.pos_y;
        end
    end

    // Blink phase: runs only in blink mode, otherwise parked visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (mode_c != MODE_BLINK) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (bus.frame_tick) begin
            if (blink_cnt == BCW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BCW'(1);
            end
        end
    end

    // Animation step: runs only in animate mode, otherwise frame 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anim_cnt <= '0;
            frame_q  <= '0;
        end else if (mode_c != MODE_ANIM) begin
            anim_cnt <= '0;
            frame_q  <= '0;
        end else if (bus.frame_tick) begin
            if (anim_cnt == FCW'(FRAME_DIV - 1)) begin
                anim_cnt <= '0;
                frame_q  <= (frame_q == FIW'(FRAMES - 1)) ? '0 : frame_q + FIW'(1);
            end else begin
                anim_cnt <= anim_cnt + FCW'(1);
            end
        end
    end

    // Hit test in a width wide enough that px+SPR_W never wraps.
    always_comb begin
        visible_c = 1'b1;
        case (mode_c)
            MODE_OFF:   visible_c = 1'b0;
            MODE_BLINK: visible_c = blink_on;
            default:    visible_c = 1'b1;
        endcase
        xe     = HW'(bus.x);
        ye     = HW'(bus.y);
        pxe    = HW'(px);
        pye    = HW'(py);
        p      = xe - pxe;
        q      = ye - pye;
        hit_c  = (xe >= pxe) && (xe < pxe + HW'(SPR_W)) &&
                 (ye >= pye) && (ye < pye + HW'(SPR_H)) && visible_c;
        addr_c = AW'(HW'(frame_q) * HW'(SPR_W * SPR_H) + q * HW'(SPR_W) + p);
    end

    // Stage 1/2 pipeline: address to ROM, hit and background ride alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q <= '0;
            hit_d1     <= 1'b0;
            bg_d1      <= '0;
            hit_d2     <= 1'b0;
            bg_d2      <= '0;
        end else begin
            rom_addr_q <= hit_c ? addr_c : '0;
            hit_d1     <= hit_c;
            bg_d1      <= bus.bg_in;
            hit_d2     <= hit_d1;
            bg_d2      <= bg_d1;
        end
    end

    // Palette lookup; index 0 is transparent.
    always_comb begin
        pix_c = bg_d2;
        if (hit_d2) begin
            case (bus.rom_data)
                2'd1:    pix_c = PAL1;
                2'd2:    pix_c = PAL2;
                2'd3:    pix_c = PAL3;
                default: pix_c = bg_d2;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q <= '0;
        end else begin
            pixel_q <= pix_c;
        end
    end

endmodule

// File: tb/tb_sprite_anim_disp.sv
// Self-checking bench for sprite_anim_disp (FRAME_DIV=2, BLINK_DIV=2).
module tb_sprite_anim_disp;

    localparam int SPR_W  = 26;
    localparam int SPR_H  = 25;
    localparam int FRAMES = 4;
    localparam int AW     = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    sprite_anim_disp_if #(.SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES)) bus ();

    sprite_anim_disp #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES),
        .FRAME_DIV(2), .BLINK_DIV(2),
        .PAL1(16'hFFFF), .PAL2(16'h8410), .PAL3(16'hF100)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Bench-owned synchronous sprite ROM.
    logic [1:0] rom_mem [0:(1<<AW)-1];
    always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

    int          m_px, m_py, m_frame;
    bit          m_vis;
    int          sx[$], sy[$];
    logic [15:0] sbg[$];
    logic [AW-1:0] exp_addr_q[$], act_addr_q[$];
    logic [15:0]   exp_pix_q[$],  act_pix_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [15:0] pal(input logic [1:0] i);
        case (i)
            2'd1:    return 16'hFFFF;
            2'd2:    return 16'h8410;
            2'd3:    return 16'hF100;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic void model_pix(input int xx, input int yy, input logic [15:0] bg,
                                      output logic [AW-1:0] a, output logic [15:0] p);
        bit hit;
        int ad;
        hit = m_vis && (xx >= m_px) && (xx < m_px + SPR_W) && (yy >= m_py) && (yy < m_py + SPR_H);
        ad  = hit ? (m_frame * SPR_W * SPR_H + (yy - m_py) * SPR_W + (xx - m_px)) : 0;
        a   = AW'(ad);
        p   = (hit && rom_mem[ad] != 2'd0) ? pal(rom_mem[ad]) : bg;
    endfunction

    task automatic push(input int xx, input int yy, input logic [15:0] bg);
        sx.push_back(xx);
        sy.push_back(yy);
        sbg.push_back(bg);
    endtask

    // Drives the queued pixels back-to-back; expected values go to the
    // scoreboard at drive time, DUT outputs are captured as they emerge.
    task automatic run_stream();
        int n;
        logic [AW-1:0] a;
        logic [15:0]   p;
        n = sx.size();
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                bus.x     = 7'(sx[i]);
                bus.y     = 6'(sy[i]);
                bus.bg_in = sbg[i];
                model_pix(sx[i], sy[i], sbg[i], a, p);
                exp_addr_q.push_back(a);
                exp_pix_q.push_back(p);
            end
            @(posedge clk); #1;
            if (i < n)  act_addr_q.push_back(bus.rom_addr);
            if (i >= 2) act_pix_q.push_back(bus.pixel_data);
        end
        sx.delete();
        sy.delete();
        sbg.delete();
    endtask

    task automatic flush_queues();
        exp_addr_q.delete();
        act_addr_q.delete();
        exp_pix_q.delete();
        act_pix_q.delete();
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #12;
        n_checks += 3;
        if (bus.pixel_data !== 16'h0) $display("FAIL reset_pix got %h exp 0000", bus.pixel_data); else n_pass++;
        if (bus.rom_addr !== '0) $display("FAIL reset_addr got %0d exp 0", bus.rom_addr); else n_pass++;
        if (bus.frame_idx !== '0) $display("FAIL reset_frame got %0d exp 0", bus.frame_idx); else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_steady();
        logic [AW-1:0] ea, aa;
        logic [15:0]   ep, ap;
        bus.mode = 2'b10; bus.pos_x = 7'd40; bus.pos_y = 6'd20;
        tick();
        m_px = 40; m_py = 20; m_frame = 0; m_vis = 1;
        rom_mem[27] = 2'd2;
        rom_mem[28] = 2'd0;
        push(41, 21, 16'hAAAA);
        push(42, 21, 16'h1234);
        push(40, 20, 16'h5555);
        run_stream();
        n_checks += 3;
        if (act_addr_q[0] !== 12'd27) $display("FAIL steady_addr27 got %0d exp 27", act_addr_q[0]); else n_pass++;
        if (act_pix_q[0] !== 16'h8410) $display("FAIL steady_pal2 got %h exp 8410", act_pix_q[0]); else n_pass++;
        if (act_pix_q[1] !== 16'h1234) $display("FAIL steady_transp got %h exp 1234", act_pix_q[1]); else n_pass++;
        while (exp_pix_q.size() != 0) begin
            ea = exp_addr_q.pop_front(); aa = act_addr_q.pop_front();
            ep = exp_pix_q.pop_front();  ap = act_pix_q.pop_front();
            n_checks += 2;
            if (aa !== ea) $display("FAIL steady_sb_addr got %0d exp %0d", aa, ea); else n_pass++;
            if (ap !== ep) $display("FAIL steady_sb_pix got %h exp %h", ap, ep); else n_pass++;
        end
    endtask

    task automatic test_clip();
        logic [AW-1:0] ea, aa;
        logic [15:0]   ep, ap;
        bus.mode = 2'b10; bus.pos_x = 7'd120; bus.pos_y = 6'd50;
        tick();
        m_px = 120; m_py = 50; m_vis = 1; m_frame = 0;
        push(127, 60, 16'h0101);
        push(0,   60, 16'h0202);
        push(119, 50, 16'h0303);
        push(120, 50, 16'h0404);
        push(127, 63, 16'h0505);
        run_stream();
        n_checks += 3;
        if (act_addr_q[0] !== 12'd267) $display("FAIL clip_addr267 got %0d exp 267", act_addr_q[0]); else n_pass++;
        if (act_addr_q[1] !== 12'd0) $display("FAIL clip_nowrap_addr got %0d exp 0", act_addr_q[1]); else n_pass++;
        if (act_pix_q[1] !== 16'h0202) $display("FAIL clip_nowrap_pix got %h exp 0202", act_pix_q[1]); else n_pass++;
        bus.pos_x = 7'd40; bus.pos_y = 6'd20;
        tick();
        m_px = 40; m_py = 20;
        push(39, 21, 16'h0606);
        push(40, 45, 16'h0707);
        push(65, 44, 16'h0808);
        run_stream();
        while (exp_pix_q.size() != 0) begin
            ea = exp_addr_q.pop_front(); aa = act_addr_q.pop_front();
            ep = exp_pix_q.pop_front();  ap = act_pix_q.pop_front();
            n_checks += 2;
            if (aa !== ea) $display("FAIL clip_sb_addr got %0d exp %0d", aa, ea); else n_pass++;
            if (ap !== ep) $display("FAIL clip_sb_pix got %h exp %h", ap, ep); else n_pass++;
        end
    endtask

    task automatic test_animate();
        int exp_f [10] = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
        bus.mode = 2'b11;
        rom_mem[677] = 2'd3;
        for (int t = 0; t < 10; t++) begin
            tick();
            n_checks++;
            if (bus.frame_idx !== 2'(exp_f[t]))
                $display("FAIL anim_frame tick %0d got %0d exp %0d", t + 1, bus.frame_idx, exp_f[t]);
            else n_pass++;
            if (t == 1) begin
                m_frame = 1;
                push(41, 21, 16'h2222);
                run_stream();
                n_checks += 2;
                if (act_addr_q[0] !== 12'd677) $display("FAIL anim_addr677 got %0d exp 677", act_addr_q[0]); else n_pass++;
                if (act_pix_q[0] !== 16'hF100) $display("FAIL anim_pal3 got %h exp F100", act_pix_q[0]); else n_pass++;
                flush_queues();
            end
        end
        bus.mode = 2'b10;
        @(posedge clk); #1;
        n_checks++;
        if (bus.frame_idx !== 2'd0) $display("FAIL anim_leave got %0d exp 0", bus.frame_idx); else n_pass++;
        m_frame = 0;
    endtask

    task automatic test_blink();
        bit vis_pat [6] = '{1, 1, 0, 0, 1, 1};
        logic [AW-1:0] ea, aa;
        logic [15:0]   ep, ap;
        bus.mode = 2'b01;
        for (int n = 0; n < 6; n++) begin
            if (n > 0) tick();
            m_vis = vis_pat[n];
            push(41, 21, 16'h0F0F);
            push(45, 25, 16'h0E0E);
            run_stream();
        end
        bus.mode = 2'b00; m_vis = 0;
        push(41, 21, 16'h0F0F);
        run_stream();
        tick();
        push(41, 21, 16'h0D0D);
        run_stream();
        bus.mode = 2'b01; m_vis = 1;
        push(41, 21, 16'h0C0C);
        run_stream();
        while (exp_pix_q.size() != 0) begin
            ea = exp_addr_q.pop_front(); aa = act_addr_q.pop_front();
            ep = exp_pix_q.pop_front();  ap = act_pix_q.pop_front();
            n_checks += 2;
            if (aa !== ea) $display("FAIL blink_sb_addr got %0d exp %0d", aa, ea); else n_pass++;
            if (ap !== ep) $display("FAIL blink_sb_pix got %h exp %h", ap, ep); else n_pass++;
        end
    endtask

    task automatic test_tear();
        logic [AW-1:0] ea, aa;
        logic [15:0]   ep, ap;
        bus.mode = 2'b10; bus.pos_x = 7'd40; bus.pos_y = 6'd20;
        tick();
        m_px = 40; m_py = 20; m_vis = 1; m_frame = 0;
        bus.pos_x = 7'd50;
        push(41, 21, 16'h3333);
        push(45, 30, 16'h3434);
        run_stream();
        n_checks++;
        if (act_addr_q[0] !== 12'd27) $display("FAIL tear_hold got %0d exp 27", act_addr_q[0]); else n_pass++;
        tick();
        m_px = 50;
        push(41, 21, 16'h3535);
        push(51, 21, 16'h3636);
        run_stream();
        while (exp_pix_q.size() != 0) begin
            ea = exp_addr_q.pop_front(); aa = act_addr_q.pop_front();
            ep = exp_pix_q.pop_front();  ap = act_pix_q.pop_front();
            n_checks += 2;
            if (aa !== ea) $display("FAIL tear_sb_addr got %0d exp %0d", aa, ea); else n_pass++;
            if (ap !== ep) $display("FAIL tear_sb_pix got %h exp %h", ap, ep); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] ea, aa;
        logic [15:0]   ep, ap;
        bus.mode = 2'b10; bus.pos_x = 7'd80; bus.pos_y = 6'd45;
        tick();
        m_px = 80; m_py = 45; m_vis = 1; m_frame = 0;
        for (int i = 0; i < 60; i++)
            push(int'($urandom_range(127, 70)), int'($urandom_range(63, 40)), 16'($urandom));
        run_stream();
        while (exp_pix_q.size() != 0) begin
            ea = exp_addr_q.pop_front(); aa = act_addr_q.pop_front();
            ep = exp_pix_q.pop_front();  ap = act_pix_q.pop_front();
            n_checks += 2;
            if (aa !== ea) $display("FAIL b2b_addr got %0d exp %0d", aa, ea); else n_pass++;
            if (ap !== ep) $display("FAIL b2b_pix got %h exp %h", ap, ep); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] ea, aa;
        logic [15:0]   ep, ap;
        bus.pos_x = 7'd40; bus.pos_y = 6'd20;
        bus.mode = 2'b11;
        for (int t = 0; t < 4; t++) tick();
        n_checks++;
        if (bus.frame_idx !== 2'd2) $display("FAIL rstmid_pre_frame got %0d exp 2", bus.frame_idx); else n_pass++;
        rom_mem[1327] = 2'd1;
        m_px = 40; m_py = 20; m_frame = 2; m_vis = 1;
        push(41, 21, 16'h4444);
        run_stream();
        n_checks++;
        if (act_pix_q[0] !== 16'hFFFF) $display("FAIL rstmid_pre_pix got %h exp FFFF", act_pix_q[0]); else n_pass++;
        flush_queues();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (bus.pixel_data !== 16'h0) $display("FAIL rstmid_pix got %h exp 0000", bus.pixel_data); else n_pass++;
        if (bus.rom_addr !== '0) $display("FAIL rstmid_addr got %0d exp 0", bus.rom_addr); else n_pass++;
        if (bus.frame_idx !== '0) $display("FAIL rstmid_frame got %0d exp 0", bus.frame_idx); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mode = 2'b10;
        #1;
        m_px = 0; m_py = 0; m_frame = 0; m_vis = 1;
        push(3, 2, 16'h4545);
        push(5, 5, 16'h4646);
        push(30, 2, 16'h4747);
        run_stream();
        while (exp_pix_q.size() != 0) begin
            ea = exp_addr_q.pop_front(); aa = act_addr_q.pop_front();
            ep = exp_pix_q.pop_front();  ap = act_pix_q.pop_front();
            n_checks += 2;
            if (aa !== ea) $display("FAIL rstmid_sb_addr got %0d exp %0d", aa, ea); else n_pass++;
            if (ap !== ep) $display("FAIL rstmid_sb_pix got %h exp %h", ap, ep); else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 2'(i ^ (i >> 2));
        bus.frame_tick = 1'b0;
        bus.mode       = 2'b00;
        bus.pos_x      = '0;
        bus.pos_y      = '0;
        bus.x          = '0;
        bus.y          = '0;
        bus.bg_in      = '0;
        m_px = 0; m_py = 0; m_frame = 0; m_vis = 0;
        test_reset();
        test_steady();
        test_clip();
        test_animate();
        test_blink();
        test_tear();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
